// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, datapath
// select codes, error codes and the instruction-class priority decode.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_e;

    localparam logic [2:0] ALU_R    = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;

    localparam logic [2:0] RDS_ALU  = 3'b000;
    localparam logic [2:0] RDS_MEM  = 3'b001;
    localparam logic [2:0] RDS_LINK = 3'b010;

    localparam logic [2:0] PC_NEXT   = 3'b000;
    localparam logic [2:0] PC_BRANCH = 3'b001;
    localparam logic [2:0] PC_JUMP   = 3'b010;
    localparam logic [2:0] PC_REG    = 3'b011;

    localparam logic [2:0] DST_RT   = 3'b000;
    localparam logic [2:0] DST_RD   = 3'b001;
    localparam logic [2:0] DST_RA   = 3'b010;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_FETCH_TO = 2'b10;
    localparam logic [1:0] ERR_MEM_TO   = 2'b11;

    typedef enum logic [3:0] {
        C_NONE, C_R, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_JAL, C_JAS, C_JR
    } iclass_e;

    // Several flags set at once resolve to the highest-priority class.
    function automatic iclass_e decode_class(
        input logic rtype, input logic ori, input logic lw, input logic sw,
        input logic beq, input logic lui, input logic jal, input logic jas,
        input logic jr
    );
        if (rtype)    return C_R;
        else if (ori) return C_ORI;
        else if (lw)  return C_LW;
        else if (sw)  return C_SW;
        else if (beq) return C_BEQ;
        else if (lui) return C_LUI;
        else if (jal) return C_JAL;
        else if (jas) return C_JAS;
        else if (jr)  return C_JR;
        else          return C_NONE;
    endfunction

    function automatic logic [2:0] class_aluop(input iclass_e c);
        case (c)
            C_ORI:       return ALU_OR;
            C_LW, C_SW:  return ALU_ADD;
            C_BEQ:       return ALU_SUB;
            C_LUI:       return ALU_LUI;
            default:     return ALU_R;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of one memory access; flags the cycle in which the
// wait would reach TIMEOUT if the access still has not completed.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= cnt + W'(1);
    end

    assign timeout = en && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencing controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB over a shared memory port and counts retirements.
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             RType,
    input  logic             ORI,
    input  logic             LW,
    input  logic             SW,
    input  logic             BEQ,
    input  logic             LUI,
    input  logic             JAL,
    input  logic             JAS,
    input  logic             JR,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [2:0]       ALUOP,
    output logic [2:0]       RegDataSrc,
    output logic [2:0]       PCSrc,
    output logic [2:0]       RegDst,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             err,
    output logic [1:0]       err_code
);

    // Memory handshake: mem_req stays high for every FETCH/MEM cycle, mem_we
    // qualifies it, and an access completes in the cycle mem_ready is high.

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [1:0] err_code_d;
    iclass_e    cls;
    logic       wait_en;
    logic       wait_clr;
    logic       timeout;

    assign cls   = decode_class(RType, ORI, LW, SW, BEQ, LUI, JAL, JAS, JR);
    assign state = state_q;

    assign wait_en  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign wait_clr = (state_d != state_q);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (wait_clr),
        .en      (wait_en),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = ERR_NONE;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_FETCH_TO;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_NONE: begin
                        state_d    = S_ERR;
                        err_code_d = ERR_ILLEGAL;
                    end
                    C_JAL, C_JAS, C_JR: state_d = S_FETCH;
                    default:            state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_BEQ:      state_d = S_FETCH;
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (cls == C_SW) ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_MEM_TO;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        retire     = 1'b0;
        ALUOP      = ALU_R;
        RegDataSrc = RDS_ALU;
        PCSrc      = PC_NEXT;
        RegDst     = DST_RT;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_JAL: begin
                        RegWrite   = 1'b1;
                        RegDst     = DST_RA;
                        RegDataSrc = RDS_LINK;
                        PCWrite    = 1'b1;
                        PCSrc      = PC_JUMP;
                        retire     = 1'b1;
                    end
                    C_JAS: begin
                        PCWrite = 1'b1;
                        PCSrc   = PC_JUMP;
                        retire  = 1'b1;
                    end
                    C_JR: begin
                        PCWrite = 1'b1;
                        PCSrc   = PC_REG;
                        retire  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                ALUOP = class_aluop(cls);
                if (cls == C_BEQ) begin
                    PCSrc   = PC_BRANCH;
                    PCWrite = Zero;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls == C_SW);
                ALUOP   = ALU_ADD;
                retire  = mem_ready && (cls == C_SW);
            end
            S_WB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                ALUOP      = class_aluop(cls);
                RegDst     = (cls == C_R)  ? DST_RD  : DST_RT;
                RegDataSrc = (cls == C_LW) ? RDS_MEM : RDS_ALU;
            end
            default: ;
        endcase
        // Reset must silence the port at once, even mid-access.
        if (!reset_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            retire     = 1'b0;
            ALUOP      = ALU_R;
            RegDataSrc = RDS_ALU;
            PCSrc      = PC_NEXT;
            RegDst     = DST_RT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retire_cnt <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
            if ((state_d == S_ERR) && (state_q != S_ERR)) begin
                err      <= 1'b1;
                err_code <= err_code_d;
            end
        end
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Sequencing controller that turns the MIPS datapath into a multi-cycle machine sharing one unified instruction/data memory port.
- Steps each instruction through fetch, decode, execute, memory and write-back states.
- Drives the datapath's existing 3-bit select encodings (ALUOP, RegDataSrc, PCSrc, RegDst) plus the write/enable strobes.
- Handles variable-latency memory (req/ready handshake), bounds each memory wait with a timeout, and counts retired instructions.

Parameters:
- TIMEOUT, 15, maximum cycles waiting for mem_ready in FETCH or MEM before entering ERR (1..255).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- RType, ORI, LW, SW, BEQ, LUI, JAL, JAS, JR  in  1 each  instruction-class flags decoded from the IR; valid from DECODE onward.
- Zero  in  1  ALU zero flag; sampled in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier for mem_req.
- IRWrite  out  1  load IR.
- PCWrite  out  1  load PC.
- RegWrite  out  1  GRF write enable.
- ALUOP  out  3  000 R, 001 or, 010 add, 011 sub/compare, 100 lui.
- RegDataSrc  out  3  000 ALU, 001 memory, 010 PC+4 link.
- PCSrc  out  3  000 PC+4, 001 branch, 010 jump target, 011 register.
- RegDst  out  3  000 rt, 001 rd, 010 $31.
- state  out  3  current state code.
- retire  out  1  one-cycle pulse when an instruction completes.
- retire_cnt  out  CNT_W  retired-instruction count.
- err  out  1  sticky error.
- err_code  out  2  01 illegal, 10 fetch timeout, 11 mem timeout.

Behaviour:
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5. Codes 6 and 7 recover to FETCH on the next clock.
- The state register is asynchronous-reset. While reset_n=0: state=FETCH, retire_cnt=0, err=0, err_code=00, and every strobe (mem_req, mem_we, IRWrite, PCWrite, RegWrite, retire) is forced to 0. Selects default to 000.
- Outputs are combinational from state and inputs. Default is all 0 / 000 unless listed below.
- FETCH:
  - mem_req=1, mem_we=0.
  - If mem_ready: IRWrite=1, PCWrite=1, PCSrc=000, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - No flag set: go to ERR with err_code=01.
  - JAL: RegWrite=1, RegDst=010, RegDataSrc=010, PCWrite=1, PCSrc=010, retire; go to FETCH.
  - JAS: PCWrite=1, PCSrc=010, retire; go to FETCH.
  - JR: PCWrite=1, PCSrc=011, retire; go to FETCH.
  - Otherwise: go to EXEC.
  - Flag priority when several are set: RType > ORI > LW > SW > BEQ > LUI > JAL > JAS > JR.
- EXEC:
  - ALUOP is driven per class (LW and SW use 010).
  - BEQ: PCSrc=001 and PCWrite=Zero, retire; go to FETCH.
  - LW or SW: go to MEM.
  - Otherwise: go to WB.
- MEM:
  - mem_req=1, mem_we=SW, ALUOP=010 held.
  - On mem_ready: LW goes to WB; SW retires and goes to FETCH.
- WB:
  - RegWrite=1, retire; go to FETCH.
  - RegDst=001 for RType, otherwise 000.
  - RegDataSrc=001 for LW, otherwise 000.
  - ALUOP is held as in EXEC.
- Wait timer:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle mem_ready=0 in that state.
  - When the count reaches TIMEOUT with mem_ready still 0, go to ERR (err_code 10 from FETCH, 11 from MEM). mem_req drops in ERR.
  - mem_ready in the same cycle the count reaches TIMEOUT takes precedence: the access completes with no error.
- ERR:
  - All strobes are 0.
  - err=1 and err_code stay held until reset_n is asserted.
- retire_cnt increments on each retire and wraps from all-ones to 0.
- Reset asserted mid-MEM drops mem_req immediately (asynchronously). A pending write must not be committed by this block.
- mem_ready outside FETCH/MEM is ignored.

Decomposition:
- Shared package (cpu_ctrl_pkg): state codes; ALUOP, RegDataSrc, PCSrc and RegDst code constants; err_code values.
- Sub-module mem_wait_timer: clear and enable inputs, timeout output, counter width $clog2(TIMEOUT+1).
- The FSM and output decode stay in multicycle_ctrl_fsm.

Test Plan:
- ORI with mem_ready=1 whenever requested -> states 0,1,2,4; RegWrite=1 with RegDst=000 only in WB; retire on cycle 4; retire_cnt=1.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req held for 4 cycles, mem_we=0; WB shows RegDataSrc=001; total 8 cycles; retire once.
- BEQ with Zero=1, then BEQ with Zero=0 -> PCWrite=1 with PCSrc=001 for the first, PCWrite=0 for the second; each retires in 3 cycles.
- JAL -> in DECODE, RegWrite=1, RegDst=010, RegDataSrc=010, PCSrc=010 and PCWrite=1 together; next state FETCH.
- TIMEOUT=15 with mem_ready stuck at 0 in FETCH -> ERR after 15 cycles, err=1, err_code=10, strobes 0 until reset. Repeat with mem_ready on cycle 15 -> no error.
- SW stalled in MEM, reset_n pulsed low -> mem_req drops immediately; after release state=0, retire_cnt=0, err=0. No flag in DECODE -> err_code=01.
